// File: rtl/ddr_pkg.sv
// Shared DDR types, widths and arbiter state encoding.
package ddr_pkg;

  localparam int unsigned DDR_ADDR_W = 32;
  localparam int unsigned DDR_DATA_W = 32;

  typedef logic [DDR_ADDR_W-1:0] ddr_address_t;
  typedef logic [DDR_DATA_W-1:0] ddr_data_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } ddr_arb_state_e;

  // Requester index width, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ddr_rr_arbiter_rr_pick.sv
// Combinational winner selection: round-robin from a pointer, or lowest index.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IW      = 2
) (
  input  logic [NUM_REQ-1:0] i_elig,
  input  logic [IW-1:0]      i_ptr,
  input  logic               i_rr_mode,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IW-1:0]      o_idx,
  output logic               o_valid
);

  int unsigned        w_cand;
  logic [NUM_REQ-1:0] w_shift;

  // Scan candidates in priority order and keep the first eligible one.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = 0;
    w_shift = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_cand  = i_rr_mode ? ((32'(i_ptr) + i) % NUM_REQ) : i;
      w_shift = i_elig >> w_cand;
      if (!o_valid && w_shift[0]) begin
        o_valid = 1'b1;
        o_grant = NUM_REQ'(1) << w_cand;
        o_idx   = IW'(w_cand);
      end
    end
  end

endmodule

// File: rtl/ddr_rr_arbiter.sv
// N-requester arbiter for the single DDR port, with registered DDR-side
// outputs, optional watchdog and grant/busy status.
module ddr_rr_arbiter
  import ddr_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned RR_MODE = 1,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NUM_REQ-1:0][DDR_ADDR_W-1:0]   req_address_i,
  input  logic [NUM_REQ-1:0]                   req_w_en_i,
  input  logic [NUM_REQ-1:0][DDR_DATA_W-1:0]   req_w_data_i,
  output logic [NUM_REQ-1:0]                   req_w_done_o,
  input  logic [NUM_REQ-1:0]                   req_r_en_i,
  output logic [NUM_REQ-1:0][DDR_DATA_W-1:0]   req_r_data_o,
  output logic [NUM_REQ-1:0]                   req_r_valid_o,
  output logic [NUM_REQ-1:0]                   req_err_o,
  output logic [DDR_ADDR_W-1:0]                ddr_address_o,
  output logic                                 ddr_w_en_o,
  output logic [DDR_DATA_W-1:0]                ddr_w_data_o,
  input  logic                                 ddr_w_done_i,
  output logic                                 ddr_r_en_o,
  input  logic [DDR_DATA_W-1:0]                ddr_r_data_i,
  input  logic                                 ddr_r_valid_i,
  output logic [NUM_REQ-1:0]                   grant_o,
  output logic                                 busy_o,
  output logic                                 timeout_o
);

  localparam int unsigned IW = idx_width(NUM_REQ);
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  ddr_arb_state_e     r_state;
  ddr_arb_state_e     w_state_nxt;
  logic [IW-1:0]      r_ptr;
  logic [IW-1:0]      r_idx;
  logic [IW-1:0]      w_idx_inc;
  logic [NUM_REQ-1:0] r_grant;
  ddr_address_t       r_addr;
  ddr_data_t          r_wdata;
  logic [CW-1:0]      r_cnt;

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_pick_grant;
  logic [IW-1:0]      w_pick_idx;
  logic               w_pick_valid;
  logic               w_hit;
  logic               w_expire;
  logic               w_finish;

  assign w_elig = req_w_en_i | req_r_en_i;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .i_elig    (w_elig),
    .i_ptr     (r_ptr),
    .i_rr_mode (RR_MODE != 0),
    .o_grant   (w_pick_grant),
    .o_idx     (w_pick_idx),
    .o_valid   (w_pick_valid)
  );

  // DDR completion only counts in the matching state; the watchdog fires
  // only when no completion arrives in the expiry cycle itself.
  always_comb begin
    w_hit    = ((r_state == ST_WRITE) && ddr_w_done_i) ||
               ((r_state == ST_READ)  && ddr_r_valid_i);
    w_expire = (TIMEOUT != 0) && (r_state != ST_IDLE) &&
               (r_cnt == TO_VAL) && !w_hit;
    w_finish = w_hit || w_expire;
  end

  assign w_idx_inc = (r_idx == IW'(NUM_REQ - 1)) ? '0 : r_idx + IW'(1);

  // Next-state decode; a winner with both enables is served as a write first.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt = (|(req_w_en_i & w_pick_grant)) ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE, ST_READ: begin
        if (w_finish) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, captured transaction, pointer and watchdog registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_grant <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE) begin
        if (w_pick_valid) begin
          r_idx   <= w_pick_idx;
          r_grant <= w_pick_grant;
          r_addr  <= req_address_i[w_pick_idx];
          r_wdata <= req_w_data_i[w_pick_idx];
          r_cnt   <= '0;
        end
      end else if (w_finish) begin
        r_grant <= '0;
        if (RR_MODE != 0) begin
          r_ptr <= w_idx_inc;
        end
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign ddr_address_o = r_addr;
  assign ddr_w_data_o  = r_wdata;
  assign ddr_w_en_o    = (r_state == ST_WRITE);
  assign ddr_r_en_o    = (r_state == ST_READ);
  assign grant_o       = r_grant;
  assign busy_o        = (r_state != ST_IDLE);
  assign timeout_o     = w_expire;

  assign req_w_done_o  = ((r_state == ST_WRITE) && w_finish) ? r_grant : '0;
  assign req_r_valid_o = ((r_state == ST_READ)  && w_finish) ? r_grant : '0;
  assign req_err_o     = w_expire ? r_grant : '0;
  assign req_r_data_o  = {NUM_REQ{ddr_r_data_i}};

endmodule

// File: tb/tb_ddr_rr_arbiter.sv
// Directed bench for ddr_rr_arbiter: one round-robin instance with a watchdog
// and one fixed-priority instance, driven from the same requester/DDR stimulus.
module tb_ddr_rr_arbiter;
  import ddr_pkg::*;

  localparam int unsigned N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                          rst;
  logic [N-1:0][DDR_ADDR_W-1:0]  addr;
  logic [N-1:0]                  w_en;
  logic [N-1:0]                  r_en;
  logic [N-1:0][DDR_DATA_W-1:0]  w_data;
  logic                          ddr_w_done;
  logic                          ddr_r_valid;
  logic [DDR_DATA_W-1:0]         ddr_r_data;

  logic [N-1:0]                  a_w_done, a_r_valid, a_err, a_grant;
  logic [N-1:0][DDR_DATA_W-1:0]  a_r_data;
  logic [DDR_ADDR_W-1:0]         a_addr;
  logic [DDR_DATA_W-1:0]         a_w_data;
  logic                          a_w_en, a_r_en, a_busy, a_to;

  logic [N-1:0]                  b_w_done, b_r_valid, b_err, b_grant;
  logic [N-1:0][DDR_DATA_W-1:0]  b_r_data;
  logic [DDR_ADDR_W-1:0]         b_addr;
  logic [DDR_DATA_W-1:0]         b_w_data;
  logic                          b_w_en, b_r_en, b_busy, b_to;

  int n_total = 0;
  int n_bad   = 0;

  ddr_rr_arbiter #(.NUM_REQ(N), .RR_MODE(1), .TIMEOUT(8)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .req_address_i(addr), .req_w_en_i(w_en), .req_w_data_i(w_data),
    .req_w_done_o(a_w_done), .req_r_en_i(r_en), .req_r_data_o(a_r_data),
    .req_r_valid_o(a_r_valid), .req_err_o(a_err),
    .ddr_address_o(a_addr), .ddr_w_en_o(a_w_en), .ddr_w_data_o(a_w_data),
    .ddr_w_done_i(ddr_w_done), .ddr_r_en_o(a_r_en), .ddr_r_data_i(ddr_r_data),
    .ddr_r_valid_i(ddr_r_valid), .grant_o(a_grant), .busy_o(a_busy),
    .timeout_o(a_to)
  );

  ddr_rr_arbiter #(.NUM_REQ(N), .RR_MODE(0), .TIMEOUT(0)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .req_address_i(addr), .req_w_en_i(w_en), .req_w_data_i(w_data),
    .req_w_done_o(b_w_done), .req_r_en_i(r_en), .req_r_data_o(b_r_data),
    .req_r_valid_o(b_r_valid), .req_err_o(b_err),
    .ddr_address_o(b_addr), .ddr_w_en_o(b_w_en), .ddr_w_data_o(b_w_data),
    .ddr_w_done_i(ddr_w_done), .ddr_r_en_o(b_r_en), .ddr_r_data_i(ddr_r_data),
    .ddr_r_valid_i(ddr_r_valid), .grant_o(b_grant), .busy_o(b_busy),
    .timeout_o(b_to)
  );

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    addr        = '0;
    w_en        = '0;
    r_en        = '0;
    w_data      = '0;
    ddr_w_done  = 1'b0;
    ddr_r_valid = 1'b0;
    ddr_r_data  = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    nxt();
    nxt();
    smp();
    n_total++;
    if ({a_w_en, a_r_en, a_busy, a_to, a_grant} !== 8'h00) begin
      n_bad++; $display("FAIL rst_a_ctrl got=%b exp=00000000", {a_w_en, a_r_en, a_busy, a_to, a_grant});
    end
    n_total++;
    if ({a_addr, a_w_data} !== 64'h0) begin
      n_bad++; $display("FAIL rst_a_addrdata got=%h exp=0", {a_addr, a_w_data});
    end
    n_total++;
    if ({a_w_done, a_r_valid, a_err} !== 12'h000) begin
      n_bad++; $display("FAIL rst_a_pulses got=%b exp=0", {a_w_done, a_r_valid, a_err});
    end
    n_total++;
    if ({b_w_en, b_r_en, b_busy, b_to, b_grant, b_w_done, b_r_valid, b_err} !== 20'h0) begin
      n_bad++; $display("FAIL rst_b_ctrl got=%h exp=0", {b_w_en, b_r_en, b_busy, b_to, b_grant, b_w_done, b_r_valid, b_err});
    end
    n_total++;
    if ({b_addr, b_w_data, b_r_data} !== '0) begin
      n_bad++; $display("FAIL rst_b_data got=%h exp=0", {b_addr, b_w_data});
    end
    rst = 1'b0;
    nxt();
  endtask

  task automatic test_single_read();
    do_reset();
    r_en[2] = 1'b1;
    addr[2] = 32'h0000_0100;
    smp();
    n_total++;
    if (a_r_en !== 1'b0) begin
      n_bad++; $display("FAIL rd_en_c0 got=%b exp=0", a_r_en);
    end
    nxt();
    smp();
    n_total++;
    if ({a_r_en, a_w_en, a_busy, a_grant} !== 7'b1010100) begin
      n_bad++; $display("FAIL rd_c1_ctrl got=%b exp=1010100", {a_r_en, a_w_en, a_busy, a_grant});
    end
    n_total++;
    if (a_addr !== 32'h0000_0100) begin
      n_bad++; $display("FAIL rd_c1_addr got=%h exp=00000100", a_addr);
    end
    nxt();
    addr[2] = 32'h0000_0999;
    nxt();
    smp();
    n_total++;
    if (a_addr !== 32'h0000_0100) begin
      n_bad++; $display("FAIL rd_addr_stable got=%h exp=00000100", a_addr);
    end
    nxt();
    nxt();
    ddr_r_valid = 1'b1;
    ddr_r_data  = 32'hDEAD_BEEF;
    smp();
    n_total++;
    if ({a_r_valid, a_err, a_w_done} !== 12'b0100_0000_0000) begin
      n_bad++; $display("FAIL rd_c5_valid got=%b exp=010000000000", {a_r_valid, a_err, a_w_done});
    end
    n_total++;
    if (a_r_data !== {4{32'hDEAD_BEEF}}) begin
      n_bad++; $display("FAIL rd_c5_data got=%h exp=%h", a_r_data, {4{32'hDEAD_BEEF}});
    end
    nxt();
    ddr_r_valid = 1'b0;
    r_en[2]     = 1'b0;
    smp();
    n_total++;
    if ({a_r_en, a_busy, a_grant, a_r_valid} !== 10'b0) begin
      n_bad++; $display("FAIL rd_c6_idle got=%b exp=0", {a_r_en, a_busy, a_grant, a_r_valid});
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0]          exp_g;
    logic [DDR_DATA_W-1:0] exp_d;
    int ord [2];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      w_en[i]   = 1'b1;
      w_data[i] = 32'hA000_0000 + 32'(i);
      addr[i]   = 32'h0000_1000 + 32'(i * 16);
    end
    for (int i = 0; i < 4; i++) begin
      exp_g = 4'b0001 << i;
      exp_d = 32'hA000_0000 + 32'(i);
      nxt();
      smp();
      n_total++;
      if ({a_grant, a_w_en, a_r_en} !== {exp_g, 2'b10}) begin
        n_bad++; $display("FAIL rr_grant_%0d got=%b exp=%b", i, {a_grant, a_w_en, a_r_en}, {exp_g, 2'b10});
      end
      n_total++;
      if ({a_w_data, a_addr} !== {exp_d, 32'h0000_1000 + 32'(i * 16)}) begin
        n_bad++; $display("FAIL rr_wdata_%0d got=%h exp=%h", i, {a_w_data, a_addr}, {exp_d, 32'h0000_1000 + 32'(i * 16)});
      end
      nxt();
      nxt();
      ddr_w_done = 1'b1;
      smp();
      n_total++;
      if (a_w_done !== exp_g) begin
        n_bad++; $display("FAIL rr_done_%0d got=%b exp=%b", i, a_w_done, exp_g);
      end
      nxt();
      ddr_w_done = 1'b0;
      w_en[i]    = 1'b0;
      smp();
      n_total++;
      if ({a_w_en, a_grant, a_w_done, a_busy} !== 10'b0) begin
        n_bad++; $display("FAIL rr_idle_%0d got=%b exp=0", i, {a_w_en, a_grant, a_w_done, a_busy});
      end
    end
    ord[0] = 0;
    ord[1] = 3;
    w_en[0]   = 1'b1;
    w_en[3]   = 1'b1;
    w_data[0] = 32'hB000_0000;
    w_data[3] = 32'hB000_0003;
    for (int k = 0; k < 2; k++) begin
      exp_g = 4'b0001 << ord[k];
      exp_d = 32'hB000_0000 + 32'(ord[k]);
      nxt();
      smp();
      n_total++;
      if ({a_grant, a_w_data} !== {exp_g, exp_d}) begin
        n_bad++; $display("FAIL rr_wrap_%0d got=%h exp=%h", k, {a_grant, a_w_data}, {exp_g, exp_d});
      end
      nxt();
      nxt();
      ddr_w_done = 1'b1;
      nxt();
      ddr_w_done    = 1'b0;
      w_en[ord[k]]  = 1'b0;
    end
  endtask

  task automatic test_read_after_write();
    do_reset();
    w_en[1]   = 1'b1;
    r_en[1]   = 1'b1;
    addr[1]   = 32'h0000_0040;
    w_data[1] = 32'h0000_1234;
    nxt();
    smp();
    n_total++;
    if ({a_grant, a_w_en, a_r_en, a_w_data} !== {4'b0010, 2'b10, 32'h0000_1234}) begin
      n_bad++; $display("FAIL rw_write_grant got=%h exp=%h", {a_grant, a_w_en, a_r_en, a_w_data}, {4'b0010, 2'b10, 32'h0000_1234});
    end
    nxt();
    ddr_w_done = 1'b1;
    smp();
    n_total++;
    if ({a_w_done, a_r_valid} !== 8'b0010_0000) begin
      n_bad++; $display("FAIL rw_write_done got=%b exp=00100000", {a_w_done, a_r_valid});
    end
    nxt();
    ddr_w_done = 1'b0;
    w_en[1]    = 1'b0;
    smp();
    n_total++;
    if ({a_w_en, a_r_en, a_grant} !== 6'b0) begin
      n_bad++; $display("FAIL rw_idle got=%b exp=0", {a_w_en, a_r_en, a_grant});
    end
    nxt();
    ddr_w_done = 1'b1;
    smp();
    n_total++;
    if ({a_grant, a_w_en, a_r_en} !== 6'b0010_01) begin
      n_bad++; $display("FAIL rw_read_grant got=%b exp=001001", {a_grant, a_w_en, a_r_en});
    end
    n_total++;
    if ({a_w_done, a_r_valid} !== 8'b0) begin
      n_bad++; $display("FAIL rw_stray_wdone got=%b exp=0", {a_w_done, a_r_valid});
    end
    nxt();
    ddr_w_done  = 1'b0;
    ddr_r_valid = 1'b1;
    ddr_r_data  = 32'hCAFE_F00D;
    smp();
    n_total++;
    if ({a_r_valid, a_err, a_busy} !== 9'b0010_0000_1) begin
      n_bad++; $display("FAIL rw_read_valid got=%b exp=001000001", {a_r_valid, a_err, a_busy});
    end
    nxt();
    ddr_r_valid = 1'b0;
    r_en[1]     = 1'b0;
    smp();
    n_total++;
    if ({a_r_en, a_busy} !== 2'b00) begin
      n_bad++; $display("FAIL rw_read_end got=%b exp=00", {a_r_en, a_busy});
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    w_en[3]   = 1'b1;
    addr[3]   = 32'h0000_0300;
    w_data[3] = 32'h5555_AAAA;
    for (int c = 0; c < 8; c++) begin
      nxt();
      smp();
      n_total++;
      if ({a_w_en, a_to, a_w_done, a_err} !== 10'b10_0000_0000) begin
        n_bad++; $display("FAIL wd_wait_%0d got=%b exp=1000000000", c, {a_w_en, a_to, a_w_done, a_err});
      end
    end
    nxt();
    smp();
    n_total++;
    if ({a_w_done, a_err, a_to} !== 9'b1000_1000_1) begin
      n_bad++; $display("FAIL wd_expire got=%b exp=100010001", {a_w_done, a_err, a_to});
    end
    nxt();
    w_en[3] = 1'b0;
    smp();
    n_total++;
    if ({a_w_en, a_busy, a_to, a_grant} !== 7'b0) begin
      n_bad++; $display("FAIL wd_after got=%b exp=0", {a_w_en, a_busy, a_to, a_grant});
    end
    nxt();
    ddr_w_done = 1'b1;
    smp();
    n_total++;
    if ({a_w_done, a_err, a_to} !== 9'b0) begin
      n_bad++; $display("FAIL wd_late_done got=%b exp=0", {a_w_done, a_err, a_to});
    end
    nxt();
    ddr_w_done = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    r_en[0] = 1'b1;
    addr[0] = 32'h0000_0200;
    nxt();
    smp();
    n_total++;
    if ({a_r_en, a_addr} !== {1'b1, 32'h0000_0200}) begin
      n_bad++; $display("FAIL mr_started got=%h exp=%h", {a_r_en, a_addr}, {1'b1, 32'h0000_0200});
    end
    nxt();
    rst = 1'b1;
    nxt();
    rst         = 1'b0;
    r_en[0]     = 1'b0;
    ddr_r_valid = 1'b1;
    ddr_r_data  = 32'h1111_2222;
    smp();
    n_total++;
    if ({a_r_en, a_w_en, a_busy, a_to, a_grant, a_r_valid, a_err} !== 16'h0) begin
      n_bad++; $display("FAIL mr_ctrl got=%b exp=0", {a_r_en, a_w_en, a_busy, a_to, a_grant, a_r_valid, a_err});
    end
    n_total++;
    if ({a_addr, a_w_data} !== 64'h0) begin
      n_bad++; $display("FAIL mr_data got=%h exp=0", {a_addr, a_w_data});
    end
    nxt();
    ddr_r_valid = 1'b0;
    smp();
    n_total++;
    if ({a_grant, a_busy} !== 5'b0) begin
      n_bad++; $display("FAIL mr_no_regrant got=%b exp=0", {a_grant, a_busy});
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    w_en[0]   = 1'b1;
    w_en[2]   = 1'b1;
    w_data[0] = 32'h0000_00F0;
    w_data[2] = 32'h0000_00F2;
    for (int r = 0; r < 3; r++) begin
      nxt();
      smp();
      n_total++;
      if ({b_grant, b_w_en, b_w_data} !== {4'b0001, 1'b1, 32'h0000_00F0}) begin
        n_bad++; $display("FAIL fp_grant_%0d got=%h exp=%h", r, {b_grant, b_w_en, b_w_data}, {4'b0001, 1'b1, 32'h0000_00F0});
      end
      nxt();
      nxt();
      ddr_w_done = 1'b1;
      smp();
      n_total++;
      if (b_w_done !== 4'b0001) begin
        n_bad++; $display("FAIL fp_done_%0d got=%b exp=0001", r, b_w_done);
      end
      nxt();
      ddr_w_done = 1'b0;
    end
    clear_inputs();
    nxt();
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_read_after_write();
    test_watchdog();
    test_reset_mid_read();
    test_fixed_priority();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ddr_rr_arbiter.md
# ddr_rr_arbiter

Parametrised N-requester arbiter in front of the single DDR port. Generalises the fixed two-requester arbiter to `NUM_REQ` requesters. Adds round-robin or fixed-priority selection, registered DDR-side outputs, a per-transaction watchdog timeout, and grant/busy status. It sits between the matmul AFU engines (weight fetch, activation fetch, result writeback) and the DDR controller interface.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥ 2.
- `RR_MODE`, 1: 1 = round-robin, 0 = fixed priority (index 0 highest).
- `TIMEOUT`, 0: cycles a granted transaction may wait for DDR completion; 0 disables the watchdog.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `req_address_i` in `NUM_REQ` x `ddr_address_t`: per-requester address.
- `req_w_en_i` in `NUM_REQ`: write request, level, held until done.
- `req_w_data_i` in `NUM_REQ` x `ddr_data_t`: write data.
- `req_w_done_o` out `NUM_REQ`: one-cycle write completion, granted requester only.
- `req_r_en_i` in `NUM_REQ`: read request, level, held until valid.
- `req_r_data_o` out `NUM_REQ` x `ddr_data_t`: `ddr_r_data_i` broadcast to all requesters.
- `req_r_valid_o` out `NUM_REQ`: one-cycle read valid, granted requester only.
- `req_err_o` out `NUM_REQ`: pulses with done/valid when the transaction timed out.
- `ddr_address_o` out `ddr_address_t`: registered DDR address.
- `ddr_w_en_o` out 1: registered DDR write enable.
- `ddr_w_data_o` out `ddr_data_t`: registered DDR write data.
- `ddr_w_done_i` in 1: DDR write completion.
- `ddr_r_en_o` out 1: registered DDR read enable.
- `ddr_r_data_i` in `ddr_data_t`: DDR read data.
- `ddr_r_valid_i` in 1: DDR read valid.
- `grant_o` out `NUM_REQ`: one-hot grant, zero when idle.
- `busy_o` out 1: FSM not in IDLE.
- `timeout_o` out 1: one-cycle pulse on watchdog expiry.

## Operation
- **FSM states:** IDLE, WRITE, READ.
- **IDLE:**
  - A requester is eligible when `w_en | r_en` is set.
  - Round-robin searches from `ptr` upward, wrapping modulo `NUM_REQ`.
  - Fixed-priority mode picks the lowest eligible index.
  - On a win: register the index, address and write data, set `grant_o`, move to WRITE if `w_en` else READ.
  - If the winner has both `w_en` and `r_en`, the write is served first. The read is served on a later grant.
- **WRITE:**
  - `ddr_w_en_o` is held high.
  - On `ddr_w_done_i`: `req_w_done_o[g]` = 1 in the same cycle (combinational), `ddr_w_en_o` clears at the next edge, and the FSM returns to IDLE.
- **READ:**
  - Same as WRITE, using `ddr_r_en_o`, `ddr_r_valid_i` and `req_r_valid_o[g]`.
- **Pointer:** in round-robin mode, `ptr` ← g+1 (wrapping) on completion.
- **Watchdog:**
  - A counter of `$clog2(TIMEOUT+1)` bits clears on entry to WRITE/READ and increments each cycle in state.
  - When it reaches `TIMEOUT` with no DDR completion: pulse done or valid plus `req_err_o[g]` and `timeout_o`, drop the DDR enable at the next edge, advance `ptr`, return to IDLE.
  - A late DDR completion arriving in IDLE is ignored.
- **DDR inputs outside the matching state** are ignored, e.g. `ddr_w_done_i` during READ.
- **Requester rule:** a requester deasserts `en` the cycle after done/valid. IDLE always lasts at least one cycle, so there is no stale re-grant.
- **Reset:**
  - All registered outputs go to 0 (`ddr_*_en_o`, `ddr_address_o`, `ddr_w_data_o`, `grant_o`, `busy_o`, `timeout_o`), with `ptr` = 0 and the FSM in IDLE.
  - Combinational done/valid/err outputs are 0 while in IDLE.
  - Reset mid-transaction abandons it silently, with no done pulse.

## Timing
- **Latency, request to DDR enable:** request seen in IDLE at cycle n → `ddr_*_en_o`, `grant_o` and `busy_o` high at n+1.
- **Completion:** DDR completion at cycle k → requester done/valid at k (0-cycle path). Enable, `grant_o` and `busy_o` are low at k+1. The earliest next grant is visible at k+2.
- **Throughput:** one transaction per (DDR latency + 2) cycles.
- **Address/data stability:** `ddr_address_o` and `ddr_w_data_o` are stable for the whole transaction, even if requester inputs change.

## Structure
- `ddr_address_t`, `ddr_data_t` and their widths (`DDR_ADDR_W`, `DDR_DATA_W`) live in the shared `ddr_pkg`.
- The FSM state enum `ddr_arb_state_e` also goes in `ddr_pkg`.
- One sub-module, `rr_pick`: purely combinational. Inputs are the eligibility vector, `ptr` and mode. Outputs are a one-hot grant and its index.
- The index width is `$clog2(NUM_REQ)`, minimum 1.

## Test plan
- **Single read:** `NUM_REQ`=4, requester 2 reads address 0x100 at cycle 0; DDR returns 0xDEADBEEF with valid at cycle 5.
  - `ddr_r_en_o` = 1 and `ddr_address_o` = 0x100 at cycle 1.
  - `req_r_valid_o` = 4'b0100 and `req_r_data_o[2]` = 0xDEADBEEF at cycle 5.
  - `ddr_r_en_o` = 0 at cycle 6.
- **Round-robin order:** all four requesters write at once; DDR done arrives 2 cycles after each enable.
  - Grants go 0, 1, 2, 3, each with the correct write data on `ddr_w_data_o`.
  - Requesters 0 and 3 then request again → 0 is granted first, since `ptr` wrapped to 0.
- **Fixed-priority starvation:** `RR_MODE`=0, requesters 0 and 2 request continuously → every grant goes to 0.
- **Same-requester read and write:** requester 1 asserts `w_en` and `r_en` together → WRITE completes, then READ is granted to requester 1 on its next eligibility.
- **Watchdog:** `TIMEOUT`=8, DDR never responds to a write.
  - In-state cycle 8: `req_w_done_o[g]`, `req_err_o[g]` and `timeout_o` pulse together.
  - `ddr_w_en_o` = 0 on the following cycle.
  - A later `ddr_w_done_i` produces no output.
- **Reset mid-read:** assert `rst_i` mid-read → all outputs are 0 the next cycle; a subsequent `ddr_r_valid_i` raises no `req_r_valid_o`.
